fetch_queue: RTL
================

# fetch_queue

Instruction queue between the fetch stage and decode. It buffers {PC, instruction} pairs returned from instruction memory and presents them in order to decode through a valid/ready handshake. It absorbs decode stalls so fetch can keep issuing addresses. A branch redirect discards every buffered entry in one cycle.

## Interface
- DEPTH, default 4: number of entries. Must be a power of two and at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_i  input  1  branch redirect; discards all entries and any push in the same cycle.
- push_valid_i  input  1  fetch presents an entry.
- push_pc_i  input  64  PC of the entry.
- push_instr_i  input  32  instruction word fetched at push_pc_i.
- push_ready_o  output  1  queue can accept an entry; equals !full.
- dec_valid_o  output  1  head entry available to decode; equals !empty.
- dec_pc_o  output  64  PC of the head entry.
- dec_instr_o  output  32  instruction of the head entry.
- dec_ready_i  input  1  decode consumes the head entry.
- count_o  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH entries, each {pc[63:0], instr[31:0]}.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - empty when wr_ptr == rd_ptr.
  - full when the low bits are equal and the MSBs differ.
  - Pointers increment modulo 2·DEPTH, so they wrap naturally with no special case.
- Push fires when push_valid_i && push_ready_o && !flush_i:
  - writes the entry at wr_ptr;
  - increments wr_ptr.
- Pop fires when dec_valid_o && dec_ready_i && !flush_i: increments rd_ptr.
- Simultaneous push and pop:
  - both take effect and count_o is unchanged.
  - When full, push_ready_o=0 even if a pop is firing; there is no full-pass-through.
  - When empty, dec_valid_o=0, so a same-cycle push is not visible to decode; there is no empty bypass.
- Flush:
  - next cycle, wr_ptr=rd_ptr=0 and count_o=0;
  - a push or pop in the same cycle is ignored;
  - storage contents are not cleared.
- Head outputs:
  - dec_pc_o and dec_instr_o are driven from storage[rd_ptr] (combinational read of registered storage).
  - When dec_valid_o=0 their value is don't-care, but they must not be X once any entry has been written since reset.
- count_o = wr_ptr − rd_ptr, computed modulo 2·DEPTH.
- Storage registers need no reset. Pointers are reset.

## Timing
- Reset (rst=1, asynchronous):
  - wr_ptr=rd_ptr=0 immediately, without waiting for a clock edge;
  - outputs: push_ready_o=1, dec_valid_o=0, count_o=0.
  - Reset asserted mid-operation drops all entries immediately.
- Push-to-visible latency is one cycle: an entry pushed at edge N appears with dec_valid_o=1 after edge N.
- Pop takes effect at the edge where dec_ready_i is high. The next entry, if any, is presented in the cycle after that edge.
- Throughput is one push and one pop per cycle when the queue is neither empty nor full.
- push_ready_o and dec_valid_o depend only on registered pointers, with no combinational path from inputs.
- Handshake rules:
  - Decode may hold dec_ready_i high with no dependency on dec_valid_o.
  - Fetch must hold push_pc_i and push_instr_i stable while push_valid_i && !push_ready_o. This is a checked assertion in verification, not enforced by the block.

## Test plan
- Reset then idle:
  - assert rst asynchronously between edges → dec_valid_o=0, push_ready_o=1 and count_o=0 without waiting for a clock edge;
  - these values hold for 5 idle cycles after rst drops.
- Fill and drain, DEPTH=4:
  - push PCs 0x0, 0x4, 0x8, 0xC (instrs 0x00000013 + index) with dec_ready_i=0 → count_o steps 1..4, and push_ready_o=0 after the 4th;
  - then raise dec_ready_i → entries pop in order 0x0..0xC on consecutive cycles, and dec_valid_o=0 afterwards.
- Full-queue simultaneous push and pop:
  - at count_o=4, push_valid_i=1 and dec_ready_i=1 → pop occurs, push is not accepted, count_o=3;
  - next cycle the push is accepted, count_o=4, and the head advances by one PC.
- Wrap-around:
  - stream 20 sequential PCs from 0x1000 with continuous pop and random push_valid_i/dec_ready_i bubbles → output PC sequence is exactly 0x1000, 0x1004, …, 0x104C, with no loss or duplication.
- Flush with traffic:
  - at count_o=3, assert flush_i together with push_valid_i=1 (PC 0x2000) and dec_ready_i=1 → next cycle count_o=0 and dec_valid_o=0, and PC 0x2000 is never output;
  - a push of PC 0x3000 one cycle later is output first.
- Reset mid-stream:
  - at count_o=2, assert rst asynchronously between edges → count_o=0 and dec_valid_o=0 immediately;
  - after release, the first pushed entry (PC 0x4000) is the first one output.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order {PC, instruction} buffer between fetch and decode. A circular
// buffer with wrap-bit pointers; flush_i empties it in one cycle.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    input  logic [63:0]                push_pc_i,
    input  logic [31:0]                push_instr_i,
    output logic                       push_ready_o,
    output logic                       dec_valid_o,
    output logic [63:0]                dec_pc_o,
    output logic [31:0]                dec_instr_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [63:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [63:0]   last_pc_reg;
    logic [31:0]   last_instr_reg;

    logic empty;
    logic full;
    logic push_fire;
    logic pop_fire;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    assign push_ready_o = !full;
    assign dec_valid_o  = !empty;
    assign count_o      = wr_ptr_reg - rd_ptr_reg;

    assign push_fire = push_valid_i && !full && !flush_i;
    assign pop_fire  = !empty && dec_ready_i && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    // Storage is never reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[wr_ptr_reg[AW-1:0]]    <= push_pc_i;
            instr_mem[wr_ptr_reg[AW-1:0]] <= push_instr_i;
            last_pc_reg                   <= push_pc_i;
            last_instr_reg                <= push_instr_i;
        end
    end

    // While empty the head slot may never have been written, so show the
    // most recently pushed entry instead to keep the outputs X-free.
    always_comb begin
        dec_pc_o    = pc_mem[rd_ptr_reg[AW-1:0]];
        dec_instr_o = instr_mem[rd_ptr_reg[AW-1:0]];
        if (empty) begin
            dec_pc_o    = last_pc_reg;
            dec_instr_o = last_instr_reg;
        end
    end

endmodule
